cube_move_seq: RTL and testbench
================================

// Module: cube_move_seq
// PURPOSE
//  Sequencer that replays a stored list of cube moves through the cube engine one move at a time.
//  Per move: fetches the code from move RAM, holds eng_run high until the engine reports finished,
//    then drops run and waits for the engine to return to idle.
//  Sits between the top-level solver control and the cube engine's run/fin interface.
//  Adds abort and a per-move watchdog timeout.
// PARAMETERS
//  MOVE_W    5     width of a move code
//  ADDR_W    8     move RAM address width; max list length 2**ADDR_W
//  MOVE_NUM  18    legal move codes are 0..MOVE_NUM-1
//  TO_W      16    watchdog counter width
//  TIMEOUT   1000  max cycles in ISSUE waiting for eng_fin (must be < 2**TO_W)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         async active-low reset
//  start      in   1         1-cycle pulse; ignored unless state==IDLE
//  abort      in   1         synchronous abort request, any state
//  seq_len    in   ADDR_W+1  number of moves; sampled on accepted start
//  mem_rd_en  out  1         move RAM read strobe
//  mem_addr   out  ADDR_W    move RAM address
//  mem_rdata  in   MOVE_W    move code, valid 1 cycle after mem_rd_en
//  eng_run    out  1         run request to cube engine
//  eng_move   out  MOVE_W    move code to engine; stable while eng_run=1
//  eng_fin    in   1         engine in finished state
//  eng_ok     in   1         engine check result; sampled with eng_fin
//  busy       out  1         state != IDLE
//  done       out  1         1-cycle pulse: whole list completed
//  error      out  1         sticky; cleared by next accepted start
//  err_code   out  2         0 none, 1 illegal move, 2 check fail, 3 timeout
//  moves_done out  ADDR_W+1  moves completed since last start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal idx, watchdog, move_reg 0.
//  States: IDLE, FETCH, RDWAIT, ISSUE, RELEASE, DONE, ERR, ABORT.
//  IDLE
//   - On start: clear error/err_code/moves_done, idx=0, latch seq_len.
//   - seq_len==0 -> DONE; else -> FETCH.
//  FETCH: mem_rd_en=1, mem_addr=idx; -> RDWAIT.
//  RDWAIT
//   - Latch mem_rdata into move_reg (drives eng_move).
//   - Code >= MOVE_NUM -> ERR, err_code=1; else -> ISSUE.
//  ISSUE
//   - eng_run=1; watchdog counts up from 0.
//   - eng_fin=1 & eng_ok=0 -> ERR, err_code=2.
//   - eng_fin=1 & eng_ok=1 -> idx++, moves_done++, -> RELEASE.
//   - Watchdog reaching TIMEOUT with eng_fin=0 -> ERR, err_code=3.
//  RELEASE: eng_run=0; when eng_fin=0: idx==len -> DONE, else -> FETCH.
//  DONE: done=1 for exactly one cycle; -> IDLE.
//  ERR
//   - error=1 (sticky), eng_run=0.
//   - Wait eng_fin=0 so the engine is back in idle, then -> IDLE.
//  ABORT
//   - abort in any non-IDLE state -> ABORT; eng_run=0 in ABORT.
//   - Wait eng_fin=0, then -> IDLE; no done, error unchanged.
//   - abort in IDLE is ignored.
//  Simultaneous events
//   - abort beats eng_fin/timeout in the same cycle: no count increment, no error.
//   - start while busy is ignored.
//  Min latency per move: FETCH+RDWAIT+ISSUE(>=1)+RELEASE(>=1) = 4 cycles.
//  Engine side: eng_run drops within 1 cycle of eng_fin=1 seen in ISSUE.
//  eng_move never changes while eng_run=1.
//  Async reset mid-move: eng_run drops immediately; engine is reset by the same rst_n.
// TESTING
//  1 len=3, RAM={0,5,17}, engine model fin 2 cycles after run, ok=1
//    -> 3 run pulses carrying moves 0,5,17; done pulse; moves_done=3; error=0.
//  2 len=0, start -> done on 2nd cycle after start; eng_run never asserted.
//  3 RAM[1]=18 (illegal), len=2 -> move 0 executes; err_code=1; moves_done=1;
//    no run for 2nd move; busy falls.
//  4 Engine returns ok=0 on move 0 -> err_code=2; eng_run low next cycle; moves_done=0.
//  5 TIMEOUT=8, engine never finishes -> err_code=3 after exactly 8 ISSUE cycles; eng_run low.
//  6 Abort during ISSUE of move 2 of 4 -> eng_run low next cycle; IDLE once eng_fin=0;
//    no done; moves_done=1. Then async rst_n mid-sequence -> all outputs 0 at once.

Source files
------------

// File: rtl/cube_move_seq.sv
// cube_move_seq: replays a stored list of cube moves through the cube engine,
// one move per run/fin handshake, with abort and a per-move watchdog.
module cube_move_seq #(
  parameter int MOVE_W   = 5,
  parameter int ADDR_W   = 8,
  parameter int MOVE_NUM = 18,
  parameter int TO_W     = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   seq_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [MOVE_W-1:0] mem_rdata,
  output logic              eng_run,
  output logic [MOVE_W-1:0] eng_move,
  input  logic              eng_fin,
  input  logic              eng_ok,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   moves_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] RDWAIT  = 3'd2;
  localparam logic [2:0] ISSUE   = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;
  localparam logic [2:0] ABORT   = 3'd7;

  localparam logic [1:0] EC_ILLEGAL = 2'd1;
  localparam logic [1:0] EC_CHECK   = 2'd2;
  localparam logic [1:0] EC_TIMEOUT = 2'd3;

  localparam logic [MOVE_W:0] MOVE_LIM = (MOVE_W+1)'(MOVE_NUM);
  localparam logic [TO_W-1:0] WD_LAST  = TO_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   len;
  logic [TO_W-1:0]   wdog;
  logic [MOVE_W-1:0] move_reg;

  // Sequencer state, move index, watchdog and status registers.
  // Abort is checked ahead of the per-state case so it wins over fin/timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      len        <= '0;
      wdog       <= '0;
      move_reg   <= '0;
      error      <= 1'b0;
      err_code   <= '0;
      moves_done <= '0;
    end else if (abort && state != IDLE) begin
      state <= ABORT;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            error      <= 1'b0;
            err_code   <= '0;
            moves_done <= '0;
            idx        <= '0;
            len        <= seq_len;
            state      <= (seq_len == '0) ? DONE : FETCH;
          end
        end
        FETCH:  state <= RDWAIT;
        RDWAIT: begin
          move_reg <= mem_rdata;
          if ({1'b0, mem_rdata} >= MOVE_LIM) begin
            error    <= 1'b1;
            err_code <= EC_ILLEGAL;
            state    <= ERR;
          end else begin
            wdog  <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_fin) begin
            if (eng_ok) begin
              idx        <= idx + 1'b1;
              moves_done <= moves_done + 1'b1;
              state      <= RELEASE;
            end else begin
              error    <= 1'b1;
              err_code <= EC_CHECK;
              state    <= ERR;
            end
          end else if (wdog == WD_LAST) begin
            error    <= 1'b1;
            err_code <= EC_TIMEOUT;
            state    <= ERR;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RELEASE: begin
          if (!eng_fin) state <= (idx == len) ? DONE : FETCH;
        end
        DONE:    state <= IDLE;
        ERR:     if (!eng_fin) state <= IDLE;
        ABORT:   if (!eng_fin) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from state so async reset clears them at once.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    eng_run   = (state == ISSUE);
    mem_rd_en = (state == FETCH);
    mem_addr  = mem_rd_en ? idx[ADDR_W-1:0] : '0;
    eng_move  = move_reg;
  end

endmodule

// File: tb/tb_cube_move_seq.sv
// Scoreboard bench for cube_move_seq with a behavioural move RAM and engine.
module tb_cube_move_seq;

  localparam int MOVE_W = 5;
  localparam int ADDR_W = 8;
  localparam int EV_RUN  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   seq_len = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [MOVE_W-1:0] mem_rdata = '0;
  logic              eng_run;
  logic [MOVE_W-1:0] eng_move;
  logic              eng_fin = 1'b0;
  logic              eng_ok;
  logic              busy, done, error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   moves_done;

  typedef struct { int kind; int val; int md; } ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [MOVE_W-1:0] ram [0:255];
  int  eng_delay  = 2;
  bit  eng_hang   = 1'b0;
  bit  eng_ok_val = 1'b1;
  int  eng_cnt    = 0;

  assign eng_ok = eng_ok_val;

  always #5 clk = ~clk;

  cube_move_seq #(.MOVE_W(5), .ADDR_W(8), .MOVE_NUM(18), .TO_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seq_len(seq_len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .eng_run(eng_run), .eng_move(eng_move), .eng_fin(eng_fin), .eng_ok(eng_ok),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .moves_done(moves_done)
  );

  // Synchronous move RAM with one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  // Engine: raises fin eng_delay cycles after run, drops it one cycle after run falls
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_fin <= 1'b0;
      eng_cnt <= 0;
    end else if (eng_run && !eng_fin) begin
      if (!eng_hang && eng_cnt + 1 >= eng_delay) eng_fin <= 1'b1;
      eng_cnt <= eng_cnt + 1;
    end else if (!eng_run) begin
      eng_fin <= 1'b0;
      eng_cnt <= 0;
    end
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push(int kind, int val, int md);
    ev_t e;
    e.kind = kind; e.val = val; e.md = md;
    exp_q.push_back(e);
  endfunction

  function automatic void take(int kind, int val, int md, string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected: got kind %0d value %0d, expected no event", name, kind, val);
    end else begin
      e = exp_q.pop_front();
      chk({name, " kind"}, kind, e.kind);
      chk({name, " value"}, val, e.val);
      chk({name, " moves_done"}, md, e.md);
    end
  endfunction

  // Monitor: turns run rises, done pulses and error rises into scoreboard events
  logic              prev_run = 1'b0;
  logic              prev_err = 1'b0;
  logic [MOVE_W-1:0] prev_move = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_run <= 1'b0;
      prev_err <= 1'b0;
    end else begin
      if (eng_run && !prev_run) take(EV_RUN, int'(eng_move), int'(moves_done), "run");
      if (eng_run && prev_run) chk("move stable", int'(eng_move), int'(prev_move));
      if (done) begin
        take(EV_DONE, 0, int'(moves_done), "done");
        chk("done no error", int'(error), 0);
      end
      if (error && !prev_err) take(EV_ERR, int'(err_code), int'(moves_done), "err");
      prev_run  <= eng_run;
      prev_err  <= error;
      prev_move <= eng_move;
    end
  end

  task automatic start_seq(input int n);
    @(posedge clk); #1;
    seq_len = (ADDR_W+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, " busy falls"}, int'(busy), 0);
    chk({name, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int issue_cyc;
    for (int i = 0; i < 256; i++) ram[i] = '0;

    // Reset state
    #12;
    chk("rst busy", int'(busy), 0);
    chk("rst eng_run", int'(eng_run), 0);
    chk("rst mem_rd_en", int'(mem_rd_en), 0);
    chk("rst done", int'(done), 0);
    chk("rst error", int'(error), 0);
    chk("rst err_code", int'(err_code), 0);
    chk("rst moves_done", int'(moves_done), 0);
    chk("rst eng_move", int'(eng_move), 0);
    #11 rst_n = 1'b1;

    // 1: three legal moves including the highest code
    ram[0] = 5'd0; ram[1] = 5'd5; ram[2] = 5'd17;
    push(EV_RUN, 0, 0); push(EV_RUN, 5, 1); push(EV_RUN, 17, 2); push(EV_DONE, 0, 3);
    start_seq(3);
    wait_idle("t1");
    chk("t1 moves_done", int'(moves_done), 3);
    chk("t1 error", int'(error), 0);

    // 2: empty list completes immediately
    push(EV_DONE, 0, 0);
    start_seq(0);
    chk("t2 done latency", int'(done), 1);
    @(posedge clk); #1;
    chk("t2 done one cycle", int'(done), 0);
    wait_idle("t2");

    // 3: illegal code in second slot
    ram[0] = 5'd3; ram[1] = 5'd18;
    push(EV_RUN, 3, 0); push(EV_ERR, 1, 1);
    start_seq(2);
    wait_idle("t3");
    chk("t3 err_code", int'(err_code), 1);
    chk("t3 moves_done", int'(moves_done), 1);

    // 4: engine check failure on first move
    ram[0] = 5'd7; eng_ok_val = 1'b0;
    push(EV_RUN, 7, 0); push(EV_ERR, 2, 0);
    start_seq(1);
    n = 0;
    @(negedge clk);
    while (!eng_fin && n < 100) begin @(negedge clk); n++; end
    chk("t4 fin seen", int'(eng_fin), 1);
    @(negedge clk);
    chk("t4 run drops", int'(eng_run), 0);
    wait_idle("t4");
    chk("t4 err_code", int'(err_code), 2);
    eng_ok_val = 1'b1;

    // 5: engine never finishes, watchdog fires
    ram[0] = 5'd4; eng_hang = 1'b1;
    push(EV_RUN, 4, 0); push(EV_ERR, 3, 0);
    start_seq(1);
    issue_cyc = 0; n = 0;
    while (!error && n < 100) begin
      @(negedge clk);
      if (eng_run) issue_cyc++;
      n++;
    end
    chk("t5 issue cycles", issue_cyc, 8);
    chk("t5 run low", int'(eng_run), 0);
    wait_idle("t5");
    chk("t5 err_code", int'(err_code), 3);
    eng_hang = 1'b0;

    // 6: abort coinciding with fin on move 2 of 4
    ram[0] = 5'd1; ram[1] = 5'd2; ram[2] = 5'd3; ram[3] = 5'd4;
    push(EV_RUN, 1, 0); push(EV_RUN, 2, 1);
    start_seq(4);
    n = 0;
    @(negedge clk);
    while (!(eng_run && eng_fin && moves_done == 1) && n < 100) begin @(negedge clk); n++; end
    chk("t6 reached move2 fin", int'(eng_run && eng_fin), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t6 run drops", int'(eng_run), 0);
    chk("t6 waits fin low", int'(busy), 1);
    wait_idle("t6");
    chk("t6 moves_done", int'(moves_done), 1);
    chk("t6 error", int'(error), 0);

    // 6b: asynchronous reset in the middle of a move
    push(EV_RUN, 1, 0); push(EV_RUN, 2, 1);
    start_seq(4);
    n = 0;
    @(negedge clk);
    while (!(eng_run && moves_done == 1) && n < 100) begin @(negedge clk); n++; end
    chk("t6b reached move2", int'(eng_run), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6b rst eng_run", int'(eng_run), 0);
    chk("t6b rst busy", int'(busy), 0);
    chk("t6b rst moves_done", int'(moves_done), 0);
    chk("t6b rst eng_move", int'(eng_move), 0);
    chk("t6b rst mem_rd_en", int'(mem_rd_en), 0);
    chk("t6b rst err", int'(error) + int'(err_code) + int'(done), 0);
    #20 rst_n = 1'b1;
    wait_idle("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global timeout: simulation did not complete, expected completion before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
